// File: rtl/scanline_loader.sv
`default_nettype none
// ============================================================================
// Module   : scanline_loader
// Summary  : Double-buffered scanline prefetcher from pixel_memory into the VGA
//            line buffer. Define SCANLINE_DOUBLE_EN for 2x vertical line doubling.
// Revision : 1.0
// ============================================================================
module scanline_loader #(
    parameter int H_PIXELS           = 640,
    parameter int V_LINES            = 480,
    parameter int ADDRESS_WIDTH      = 22,
    parameter int LINE_ADDRESS_WIDTH = 13,
    parameter int DATA_WIDTH         = 12,
    parameter int READ_LATENCY       = 1
) (
    input  logic                          system_clock,
    input  logic                          reset_sync,
    input  logic                          enable,
    input  logic                          line_finished,
    output logic [ADDRESS_WIDTH-1:0]      fb_read_address,
    input  logic [DATA_WIDTH-1:0]         fb_read_data,
    output logic [LINE_ADDRESS_WIDTH-1:0] line_write_address,
    output logic [DATA_WIDTH-1:0]         line_write_data,
    output logic                          line_write_enable,
    output logic                          display_bank,
    output logic                          ready,
    output logic                          underrun,
    output logic [11:0]                   current_line
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_PRIME  = 3'd1,
        S_PRIME2 = 3'd2,
        S_WAIT   = 3'd3,
        S_FILL   = 3'd4
    } state_t;

    localparam logic [LINE_ADDRESS_WIDTH-1:0] c_COL_LAST   = LINE_ADDRESS_WIDTH'(H_PIXELS - 1);
    localparam logic [LINE_ADDRESS_WIDTH-1:0] c_BANK1_BASE = LINE_ADDRESS_WIDTH'(H_PIXELS);
    localparam logic [LINE_ADDRESS_WIDTH-1:0] c_LINE_ONE   = LINE_ADDRESS_WIDTH'(1);
    localparam logic [ADDRESS_WIDTH-1:0]      c_ROW_STRIDE = ADDRESS_WIDTH'(H_PIXELS);
    localparam logic [ADDRESS_WIDTH-1:0]      c_ADDR_ONE   = ADDRESS_WIDTH'(1);
    localparam logic [11:0]                   c_LINE_LAST  = 12'(V_LINES - 1);
    localparam logic [11:0]                   c_COUNT_ONE  = 12'd1;

    state_t                          r_state;
    state_t                          w_state_next;

    logic [2:0]                      r_sync;
    logic                            w_line_event;

    logic                            r_issue_valid;
    logic [LINE_ADDRESS_WIDTH-1:0]   r_col;
    logic [LINE_ADDRESS_WIDTH-1:0]   r_issue_line_addr;
    logic [ADDRESS_WIDTH-1:0]        r_fb_addr;
    logic [READ_LATENCY-1:0]         r_pipe_valid;
    logic [LINE_ADDRESS_WIDTH-1:0]   r_pipe_addr [READ_LATENCY];
    logic                            w_fill_done;

    logic [11:0]                     r_next_line;
    logic [11:0]                     w_next_line_inc;
    logic                            w_next_line_wrap;
    logic [ADDRESS_WIDTH-1:0]        r_next_row_base;
    logic                            w_row_advance;

    logic                            r_display_bank;
    logic                            r_ready;
    logic                            r_underrun;
    logic                            r_pending;
    logic [11:0]                     r_current_line;

    logic                            w_start_fill;
    logic                            w_fill_bank;
    logic                            w_swap;
    logic                            w_set_ready;
    logic                            w_set_pending;
    logic                            w_clear_pending;
    logic                            w_set_underrun;

    // line_finished comes from the vga_clock domain: 2-FF sync plus edge detect
    always_ff @(posedge system_clock or posedge reset_sync) begin
        if (reset_sync) begin
            r_sync <= 3'b000;
        end else begin
            r_sync <= {r_sync[1:0], line_finished};
        end
    end

    assign w_line_event = r_sync[1] & ~r_sync[2];

    assign w_fill_done      = !r_issue_valid && (r_pipe_valid == '0);
    assign w_next_line_inc  = r_next_line + c_COUNT_ONE;
    assign w_next_line_wrap = (r_next_line == c_LINE_LAST);

`ifdef SCANLINE_DOUBLE_EN
    // Source row is line>>1, so the base only moves on even output lines
    assign w_row_advance = ~w_next_line_inc[0];
`else
    assign w_row_advance = 1'b1;
`endif

    always_ff @(posedge system_clock or posedge reset_sync) begin
        if (reset_sync) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_start_fill    = 1'b0;
        w_fill_bank     = 1'b0;
        w_swap          = 1'b0;
        w_set_ready     = 1'b0;
        w_set_pending   = 1'b0;
        w_clear_pending = 1'b0;
        w_set_underrun  = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (enable) begin
                    w_state_next = S_PRIME;
                    w_start_fill = 1'b1;
                    w_fill_bank  = 1'b0;
                end
            end
            S_PRIME: begin
                if (w_fill_done) begin
                    w_state_next = S_PRIME2;
                    w_start_fill = 1'b1;
                    w_fill_bank  = 1'b1;
                    w_set_ready  = 1'b1;
                end
            end
            S_PRIME2: begin
                if (w_fill_done) begin
                    w_state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (w_line_event) begin
                    w_state_next = S_FILL;
                    w_swap       = 1'b1;
                    w_start_fill = 1'b1;
                    w_fill_bank  = r_display_bank;
                end
            end
            S_FILL: begin
                if (w_line_event) begin
                    w_set_underrun = 1'b1;
                end
                if (w_fill_done) begin
                    // A deferred (or coincident) boundary swaps now and refills at once
                    if (r_pending || w_line_event) begin
                        w_swap          = 1'b1;
                        w_start_fill    = 1'b1;
                        w_fill_bank     = r_display_bank;
                        w_clear_pending = 1'b1;
                    end else begin
                        w_state_next = S_WAIT;
                    end
                end else if (w_line_event) begin
                    w_set_pending = 1'b1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase

        if (!enable) begin
            w_state_next    = S_IDLE;
            w_start_fill    = 1'b0;
            w_swap          = 1'b0;
            w_set_ready     = 1'b0;
            w_set_pending   = 1'b0;
            w_clear_pending = 1'b0;
            w_set_underrun  = 1'b0;
        end
    end

    // Read issue: one address per cycle, row base advanced by addition only
    always_ff @(posedge system_clock or posedge reset_sync) begin
        if (reset_sync) begin
            r_issue_valid     <= 1'b0;
            r_col             <= '0;
            r_issue_line_addr <= '0;
            r_fb_addr         <= '0;
            r_next_line       <= '0;
            r_next_row_base   <= '0;
        end else if (!enable) begin
            r_issue_valid     <= 1'b0;
            r_col             <= '0;
            r_issue_line_addr <= '0;
            r_fb_addr         <= '0;
            r_next_line       <= '0;
            r_next_row_base   <= '0;
        end else if (w_start_fill) begin
            r_issue_valid     <= 1'b1;
            r_col             <= '0;
            r_issue_line_addr <= w_fill_bank ? c_BANK1_BASE : '0;
            r_fb_addr         <= r_next_row_base;
            r_next_line       <= w_next_line_wrap ? '0 : w_next_line_inc;
            if (w_next_line_wrap) begin
                r_next_row_base <= '0;
            end else if (w_row_advance) begin
                r_next_row_base <= r_next_row_base + c_ROW_STRIDE;
            end
        end else if (r_issue_valid) begin
            if (r_col == c_COL_LAST) begin
                r_issue_valid <= 1'b0;
            end else begin
                r_col             <= r_col + c_LINE_ONE;
                r_issue_line_addr <= r_issue_line_addr + c_LINE_ONE;
                r_fb_addr         <= r_fb_addr + c_ADDR_ONE;
            end
        end
    end

    // Valid/address delay line matching the framebuffer read latency
    always_ff @(posedge system_clock or posedge reset_sync) begin
        if (reset_sync) begin
            r_pipe_valid <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                r_pipe_addr[i] <= '0;
            end
        end else if (!enable) begin
            r_pipe_valid <= '0;
        end else begin
            r_pipe_valid[0] <= r_issue_valid;
            r_pipe_addr[0]  <= r_issue_line_addr;
            for (int i = 1; i < READ_LATENCY; i++) begin
                r_pipe_valid[i] <= r_pipe_valid[i-1];
                r_pipe_addr[i]  <= r_pipe_addr[i-1];
            end
        end
    end

    // Display status; underrun survives an enable abort, only reset clears it
    always_ff @(posedge system_clock or posedge reset_sync) begin
        if (reset_sync) begin
            r_display_bank <= 1'b0;
            r_current_line <= '0;
            r_ready        <= 1'b0;
            r_pending      <= 1'b0;
            r_underrun     <= 1'b0;
        end else begin
            if (w_set_underrun) begin
                r_underrun <= 1'b1;
            end
            if (!enable) begin
                r_display_bank <= 1'b0;
                r_current_line <= '0;
                r_ready        <= 1'b0;
                r_pending      <= 1'b0;
            end else begin
                if (w_swap) begin
                    r_display_bank <= ~r_display_bank;
                    r_current_line <= (r_current_line == c_LINE_LAST) ? '0
                                      : r_current_line + c_COUNT_ONE;
                end
                if (w_set_ready) begin
                    r_ready <= 1'b1;
                end
                if (w_clear_pending) begin
                    r_pending <= 1'b0;
                end else if (w_set_pending) begin
                    r_pending <= 1'b1;
                end
            end
        end
    end

    assign fb_read_address    = r_fb_addr;
    assign line_write_enable  = r_pipe_valid[READ_LATENCY-1];
    assign line_write_address = r_pipe_addr[READ_LATENCY-1];
    assign line_write_data    = line_write_enable ? fb_read_data : '0;
    assign display_bank       = r_display_bank;
    assign ready              = r_ready;
    assign underrun           = r_underrun;
    assign current_line       = r_current_line;

endmodule
`default_nettype wire

// File: tb/tb_scanline_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_scanline_loader
// Summary  : Directed self-checking bench for scanline_loader (small geometry).
// Revision : 1.0
// ============================================================================
module tb_scanline_loader;

    localparam int H_PIXELS           = 16;
    localparam int V_LINES            = 6;
    localparam int ADDRESS_WIDTH      = 22;
    localparam int LINE_ADDRESS_WIDTH = 6;
    localparam int DATA_WIDTH         = 12;
    localparam int READ_LATENCY       = 2;
    localparam int FILL_CYCLES        = H_PIXELS + READ_LATENCY + 1;

    logic                          system_clock;
    logic                          reset_sync;
    logic                          enable;
    logic                          line_finished;
    logic [ADDRESS_WIDTH-1:0]      fb_read_address;
    logic [DATA_WIDTH-1:0]         fb_read_data;
    logic [LINE_ADDRESS_WIDTH-1:0] line_write_address;
    logic [DATA_WIDTH-1:0]         line_write_data;
    logic                          line_write_enable;
    logic                          display_bank;
    logic                          ready;
    logic                          underrun;
    logic [11:0]                   current_line;

    scanline_loader #(
        .H_PIXELS           (H_PIXELS),
        .V_LINES            (V_LINES),
        .ADDRESS_WIDTH      (ADDRESS_WIDTH),
        .LINE_ADDRESS_WIDTH (LINE_ADDRESS_WIDTH),
        .DATA_WIDTH         (DATA_WIDTH),
        .READ_LATENCY       (READ_LATENCY)
    ) dut (
        .system_clock       (system_clock),
        .reset_sync         (reset_sync),
        .enable             (enable),
        .line_finished      (line_finished),
        .fb_read_address    (fb_read_address),
        .fb_read_data       (fb_read_data),
        .line_write_address (line_write_address),
        .line_write_data    (line_write_data),
        .line_write_enable  (line_write_enable),
        .display_bank       (display_bank),
        .ready              (ready),
        .underrun           (underrun),
        .current_line       (current_line)
    );

    initial system_clock = 1'b0;
    always #5 system_clock = ~system_clock;

    // Framebuffer returns address[11:0] two cycles after the address
    logic [11:0] fb_d1, fb_d2;
    always @(posedge system_clock) begin
        fb_d1 <= fb_read_address[11:0];
        fb_d2 <= fb_d1;
    end
    assign fb_read_data = fb_d2;

    logic [DATA_WIDTH-1:0] lb [2**LINE_ADDRESS_WIDTH];
    int cyc = 0;
    int wr_count = 0;
    int run_len = 0;
    int last_run = 0;

    always @(posedge system_clock) begin
        cyc <= cyc + 1;
        if (line_write_enable === 1'b1) begin
            lb[line_write_address] <= line_write_data;
            wr_count <= wr_count + 1;
            run_len  <= run_len + 1;
        end else if (run_len != 0) begin
            last_run <= run_len;
            run_len  <= 0;
        end
    end

    int passed = 0;
    int total  = 0;
    int exp_cur, exp_next, f_line, t0, n, wr_snap;
    logic exp_bank, f_bank;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    function automatic int src_row(input int line);
`ifdef SCANLINE_DOUBLE_EN
        return line >> 1;
`else
        return line;
`endif
    endfunction

    task automatic check_bank(input string tag, input logic bank, input int line);
        int mism;
        mism = 0;
        for (int i = 0; i < H_PIXELS; i++) begin
            if (lb[int'(bank) * H_PIXELS + i] !== DATA_WIDTH'(src_row(line) * H_PIXELS + i))
                mism++;
        end
        check(tag, mism, 0);
    endtask

    // Expected effect of one bank swap: returns the line fetched and its bank
    task automatic model_swap();
        f_bank   = exp_bank;
        exp_bank = ~exp_bank;
        exp_cur  = (exp_cur + 1) % V_LINES;
        f_line   = exp_next;
        exp_next = (exp_next + 1) % V_LINES;
    endtask

    task automatic pulse_line();
        line_finished = 1'b1;
        repeat (4) @(negedge system_clock);
        line_finished = 1'b0;
    endtask

    task automatic prime_and_check(input string tag);
        @(negedge system_clock);
        t0 = cyc;
        check({tag, "_addr0"}, fb_read_address, 0);
        @(negedge system_clock);
        check({tag, "_addr1"}, fb_read_address, 1);
        check({tag, "_no_early_we"}, line_write_enable, 0);
        @(negedge system_clock);
        check({tag, "_first_we"}, line_write_enable, 1);
        check({tag, "_first_wa"}, line_write_address, 0);
        @(negedge system_clock);
        check({tag, "_second_wa"}, line_write_address, 1);
        check({tag, "_second_wd"}, line_write_data, 1);
        n = 0;
        while (ready !== 1'b1 && n < 200) begin
            @(negedge system_clock);
            n++;
        end
        check({tag, "_ready_latency"}, cyc - t0, FILL_CYCLES);
        check({tag, "_bank_at_ready"}, display_bank, 0);
        repeat (FILL_CYCLES + 6) @(negedge system_clock);
        check_bank({tag, "_bank0_line0"}, 1'b0, 0);
        check_bank({tag, "_bank1_line1"}, 1'b1, 1);
        check({tag, "_run"}, last_run, H_PIXELS);
        check({tag, "_cur"}, current_line, 0);
        exp_cur = 0; exp_bank = 1'b0; exp_next = 2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_sync = 1'b1; enable = 1'b0; line_finished = 1'b0;
        repeat (3) @(negedge system_clock);
        check("rst_addr", fb_read_address, 0);
        check("rst_we", line_write_enable, 0);
        check("rst_wa", line_write_address, 0);
        check("rst_wd", line_write_data, 0);
        check("rst_bank", display_bank, 0);
        check("rst_ready", ready, 0);
        check("rst_underrun", underrun, 0);
        check("rst_cur", current_line, 0);
        reset_sync = 1'b0;
        @(negedge system_clock);
        check("idle_ready", ready, 0);
        enable = 1'b1;
        prime_and_check("prime");

        // First swap with exact sync latency
        line_finished = 1'b1;
        repeat (2) @(negedge system_clock);
        check("swap_not_early", display_bank, 0);
        @(negedge system_clock);
        model_swap();
        check("swap_bank", display_bank, exp_bank);
        check("swap_cur", current_line, exp_cur);
        check("swap_addr", fb_read_address, src_row(f_line) * H_PIXELS);
        @(negedge system_clock);
        line_finished = 1'b0;
        repeat (FILL_CYCLES + 6) @(negedge system_clock);
        check_bank("swap_refill", f_bank, f_line);
        check("swap_run", last_run, H_PIXELS);

        // Run through the frame end; line 0 is refetched from address 0
        for (int i = 0; i < V_LINES; i++) begin
            pulse_line();
            repeat (FILL_CYCLES + 7) @(negedge system_clock);
            model_swap();
            check($sformatf("wrap_cur_%0d", i), current_line, exp_cur);
            check($sformatf("wrap_bank_%0d", i), display_bank, exp_bank);
            check_bank($sformatf("wrap_fill_%0d", i), f_bank, f_line);
            check($sformatf("wrap_run_%0d", i), last_run, H_PIXELS);
            check($sformatf("wrap_underrun_%0d", i), underrun, 0);
        end

        // Second boundary arrives 8 cycles into a fill
        pulse_line();
        model_swap();
        repeat (4) @(negedge system_clock);
        line_finished = 1'b1;
        repeat (3) @(negedge system_clock);
        check("ur_flag", underrun, 1);
        check("ur_no_swap", display_bank, exp_bank);
        @(negedge system_clock);
        line_finished = 1'b0;
        repeat (9) @(negedge system_clock);
        check("ur_deferred_not_early", display_bank, exp_bank);
        @(negedge system_clock);
        check_bank("ur_first_fill", f_bank, f_line);
        model_swap();
        check("ur_deferred_bank", display_bank, exp_bank);
        check("ur_deferred_cur", current_line, exp_cur);
        check("ur_deferred_addr", fb_read_address, src_row(f_line) * H_PIXELS);
        repeat (FILL_CYCLES + 6) @(negedge system_clock);
        check_bank("ur_second_fill", f_bank, f_line);
        check("ur_run", last_run, H_PIXELS);
        check("ur_sticky", underrun, 1);

        // Abort mid-fill
        pulse_line();
        repeat (2) @(negedge system_clock);
        check("abort_we_before", line_write_enable, 1);
        enable = 1'b0;
        @(negedge system_clock);
        check("abort_we", line_write_enable, 0);
        check("abort_ready", ready, 0);
        check("abort_bank", display_bank, 0);
        check("abort_cur", current_line, 0);
        check("abort_underrun_kept", underrun, 1);
        wr_snap = wr_count;
        repeat (4) @(negedge system_clock);
        check("abort_no_writes", wr_count, wr_snap);
        enable = 1'b1;
        prime_and_check("reprime");

        // Asynchronous reset in the middle of a fill
        pulse_line();
        repeat (2) @(negedge system_clock);
        check("rstfill_we_before", line_write_enable, 1);
        #2 reset_sync = 1'b1;
        #1;
        check("rstfill_we", line_write_enable, 0);
        check("rstfill_ready", ready, 0);
        check("rstfill_underrun", underrun, 0);
        check("rstfill_bank", display_bank, 0);
        check("rstfill_cur", current_line, 0);
        wr_snap = wr_count;
        repeat (3) @(negedge system_clock);
        check("rstfill_no_writes", wr_count, wr_snap);
        reset_sync = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
